// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/funct constants used by controlUnit and the
// fetch stage, fetch FSM state encodings and instruction field helpers.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_JR  = 6'h08;

  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_REQ  = 2'd0;
  localparam fetch_state_t ST_WAIT = 2'd1;
  localparam fetch_state_t ST_EXEC = 2'd2;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[OPCODE_LSB +: 6];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] word);
    return word[FUNCT_LSB +: 6];
  endfunction

  function automatic logic [31:0] imm_sext(input logic [31:0] word);
    return {{16{word[IMM_LSB + 15]}}, word[IMM_LSB +: 16]};
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection: jr > j/jal > taken beq/bne > sequential.
// Pure combinational, all arithmetic wraps modulo 2^ADDR_WIDTH.
module next_pc_logic
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic [ADDR_WIDTH-1:0] pc_plus1,
  input  logic [31:0]           instr,
  input  logic [31:0]           rs_data,
  input  logic                  Branch,
  input  logic                  Jump,
  input  logic                  PcSrc,
  input  logic                  alu_zero,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  logic [5:0]            op;
  logic [ADDR_WIDTH-1:0] imm;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  taken;
  logic                  unused;

  assign op            = opcode_of(instr);
  assign imm           = ADDR_WIDTH'(imm_sext(instr));
  assign branch_target = pc_plus1 + imm;
  // opcode bit 0 distinguishes bne (1) from beq (0)
  assign taken         = op[0] ? !alu_zero : alu_zero;
  assign unused        = ^{instr, rs_data};

  // controlUnit does not raise Jump for jal, so its opcode is decoded here
  always_comb begin
    next_pc = pc_plus1;
    if (PcSrc) begin
      next_pc = rs_data[ADDR_WIDTH-1:0];
    end else if (Jump || op == OP_JAL) begin
      next_pc = instr[ADDR_WIDTH-1:0];
    end else if (Branch && taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle fetch stage: owns the PC, requests words from a variable-latency
// instruction memory with timeout/reissue, and presents the instruction register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  input  logic                  stall,
  input  logic                  Branch,
  input  logic                  Jump,
  input  logic                  PcSrc,
  input  logic                  alu_zero,
  input  logic [31:0]           rs_data,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [5:0]            opCode,
  output logic [5:0]            funct,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] pc_plus1,
  output logic                  imem_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [CW-1:0]         wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      instr    <= '0;
      imem_err <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // a response on the timeout cycle is still accepted
          if (imem_rvalid) begin
            instr <= imem_rdata;
            state <= ST_EXEC;
          end else if (wait_cnt == CW'(TIMEOUT)) begin
            imem_err <= 1'b1;
            state    <= ST_REQ;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            pc    <= next_pc;
            state <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  // request is suppressed while reset is held so it first appears after release
  assign imem_req    = (state == ST_REQ) && !rst;
  assign imem_addr   = pc;
  assign instr_valid = (state == ST_EXEC);
  assign opCode      = opcode_of(instr);
  assign funct       = funct_of(instr);
  assign pc_out      = pc;
  assign pc_plus1    = pc + ADDR_WIDTH'(1);

  next_pc_logic #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc (
    .pc_plus1 (pc_plus1),
    .instr    (instr),
    .rs_data  (rs_data),
    .Branch   (Branch),
    .Jump     (Jump),
    .PcSrc    (PcSrc),
    .alu_zero (alu_zero),
    .next_pc  (next_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed fetch/execute steps with a
// transaction-level next-PC model and hand-computed address expectations.
module tb_fetch_unit;

  localparam int AW  = 10;
  localparam int MOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          stall = 1'b0;
  logic          Branch = 1'b0;
  logic          Jump = 1'b0;
  logic          PcSrc = 1'b0;
  logic          alu_zero = 1'b0;
  logic [31:0]   rs_data = '0;
  logic [31:0]   instr;
  logic          instr_valid;
  logic [5:0]    opCode;
  logic [5:0]    funct;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] pc_plus1;
  logic          imem_err;

  int          total = 0;
  int          passed = 0;
  int          exp_pc = 0;
  logic [31:0] exp_instr = '0;
  logic        exp_err = 1'b0;
  bit          mon_en = 1'b0;

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (10'd0),
    .TIMEOUT    (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .Branch      (Branch),
    .Jump        (Jump),
    .PcSrc       (PcSrc),
    .alu_zero    (alu_zero),
    .rs_data     (rs_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .opCode      (opCode),
    .funct       (funct),
    .pc_out      (pc_out),
    .pc_plus1    (pc_plus1),
    .imem_err    (imem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Architectural next-PC rule in plain integer arithmetic
  function automatic int model_next(input int pc, input logic [31:0] w, input logic b,
                                    input logic j, input logic p, input logic z,
                                    input logic [31:0] rs);
    int          op;
    int          imm;
    logic [15:0] lo;
    op  = int'(w >> 26);
    lo  = w[15:0];
    imm = int'($signed(lo));
    if (p) return int'(rs % 32'(MOD));
    if (j || op == 3) return int'(w % 32'(MOD));
    if (b && ((op % 2 == 0) ? z : !z)) return (((pc + 1 + imm) % MOD) + MOD) % MOD;
    return (pc + 1) % MOD;
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (imem_req) check("mon_req_addr", 32'(imem_addr), exp_pc);
      if (instr_valid) begin
        check("mon_pc_out", 32'(pc_out), exp_pc);
        check("mon_instr", instr, exp_instr);
        check("mon_opcode", 32'(opCode), exp_instr >> 26);
        check("mon_funct", 32'(funct), exp_instr % 64);
        check("mon_pc_plus1", 32'(pc_plus1), (exp_pc + 1) % MOD);
        if (!stall) exp_pc = model_next(exp_pc, exp_instr, Branch, Jump, PcSrc, alu_zero, rs_data);
      end
      check("mon_err", 32'(imem_err), 32'(exp_err));
    end
  end

  task automatic wait_req(input int exp_addr, input string tag);
    int n = 0;
    @(negedge clk);
    while (imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 32'(imem_req), 1);
    check({tag, "_addr"}, 32'(imem_addr), exp_addr);
  endtask

  // Leaves time at posedge+1 of the first EXEC cycle
  task automatic fetch(input int addr, input logic [31:0] word, input int lat, input string tag);
    wait_req(addr, tag);
    exp_instr = word;
    repeat (lat) begin
      @(posedge clk); #1;
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    check({tag, "_wait_noreq"}, 32'(imem_req), 0);
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEADBEEF;
  endtask

  task automatic exec(input int pc_lit, input int pp1_lit, input logic b, input logic j,
                      input logic p, input logic z, input logic [31:0] rs,
                      input int stalls, input string tag);
    Branch = b; Jump = j; PcSrc = p; alu_zero = z; rs_data = rs;
    for (int i = 0; i < stalls; i++) begin
      stall       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0BAD0;
      @(negedge clk);
      check({tag, "_stall_valid"}, 32'(instr_valid), 1);
      check({tag, "_stall_noreq"}, 32'(imem_req), 0);
      check({tag, "_stall_pc"}, 32'(pc_out), pc_lit);
      @(posedge clk); #1;
    end
    stall       = 1'b0;
    imem_rvalid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, 32'(instr_valid), 1);
    check({tag, "_pc"}, 32'(pc_out), pc_lit);
    check({tag, "_pc_plus1"}, 32'(pc_plus1), pp1_lit);
    @(posedge clk); #1;
    Branch = 1'b0; Jump = 1'b0; PcSrc = 1'b0; alu_zero = 1'b0; rs_data = '0;
  endtask

  task automatic step(input int addr, input logic [31:0] word, input int lat, input logic b,
                      input logic j, input logic p, input logic z, input logic [31:0] rs,
                      input int stalls, input int pp1, input string tag);
    fetch(addr, word, lat, tag);
    exec(addr, pp1, b, j, p, z, rs, stalls, tag);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_instr", instr, 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_err", 32'(imem_err), 0);
    @(posedge clk); #1;
    rst = 1'b0; exp_pc = 0; mon_en = 1'b1;

    //   addr    word          lat b  j  p  z  rs       stl pp1
    step(0,      32'h20080005, 1,  0, 0, 0, 0, 32'h0,   0,  1,     "addi");
    step(1,      32'h00000000, 1,  0, 0, 0, 0, 32'h0,   0,  2,     "seq1");
    step(2,      32'h00000000, 2,  0, 0, 0, 0, 32'h0,   0,  3,     "seq2_lat2");
    step(3,      32'h00000000, 1,  0, 0, 0, 0, 32'h0,   0,  4,     "seq3");
    step(4,      32'h1000FFFE, 1,  1, 0, 0, 1, 32'h0,   0,  5,     "beq_taken");
    step(3,      32'h00000000, 1,  0, 0, 0, 0, 32'h0,   0,  4,     "seq3b");
    step(4,      32'h1000FFFE, 1,  1, 0, 0, 0, 32'h0,   0,  5,     "beq_not");
    step(5,      32'h08000004, 1,  0, 1, 0, 0, 32'h0,   0,  6,     "j4a");
    step(4,      32'h1400FFFE, 1,  1, 0, 0, 1, 32'h0,   0,  5,     "bne_not");
    step(5,      32'h08000004, 1,  0, 1, 0, 0, 32'h0,   0,  6,     "j4b");
    step(4,      32'h1400FFFE, 1,  1, 0, 0, 0, 32'h0,   0,  5,     "bne_taken");
    step(3,      32'h08000007, 1,  0, 1, 0, 0, 32'h0,   0,  4,     "j7");
    step(7,      32'h0C000040, 1,  0, 0, 0, 0, 32'h0,   0,  8,     "jal");
    step(10'h40, 32'h03E00008, 1,  0, 0, 1, 0, 32'h123, 0,  10'h41, "jr");
    step(10'h123, 32'h00000000, 1, 0, 0, 0, 0, 32'h0,   4,  10'h124, "stall4");

    // no response for 16 WAIT cycles: error flag and reissue at the same address
    wait_req(10'h124, "to_first");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("to_wait_noreq", 32'(imem_req), 0);
    end
    @(posedge clk); #1;
    exp_err = 1'b1;
    step(10'h124, 32'h00000000, 1, 0, 0, 0, 0, 32'h0, 0, 10'h125, "to_reissue");
    check("to_err_sticky", 32'(imem_err), 1);

    // response on the last WAIT cycle before timeout is captured, no reissue
    step(10'h125, 32'h00000000, 16, 0, 0, 0, 0, 32'h0, 0, 10'h126, "to_edge");
    step(10'h126, 32'h080003FF, 1,  0, 1, 0, 0, 32'h0, 0, 10'h127, "j3ff");
    step(10'h3FF, 32'h00000000, 1,  0, 0, 0, 0, 32'h0, 0, 0,       "wrap");

    // reset during WAIT, then a stray late response while in REQ
    wait_req(0, "wrap_next");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; exp_pc = 0; exp_err = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFFFFFFFF;
    @(negedge clk);
    check("prst_req", 32'(imem_req), 1);
    check("prst_addr", 32'(imem_addr), 0);
    check("prst_err", 32'(imem_err), 0);
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    @(negedge clk);
    check("prst_stray_instr", instr, 0);
    check("prst_stray_valid", 32'(instr_valid), 0);
    exp_instr = 32'h20080005;
    @(posedge clk); #1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h20080005;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    exec(0, 1, 0, 0, 0, 0, 32'h0, 0, "prst_exec");
    wait_req(1, "prst_next");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
